// File: rtl/t_toggle_req.sv
// ---------------------------------------------------------------------------
// t_toggle_req
//
// Purpose:
//   Debounced toggle-request generator for a T flip-flop stage. A raw,
//   asynchronous push-button level is synchronized and then debounced by a
//   four-state FSM. Each accepted press produces one single-cycle `t` pulse,
//   provided `en` is high at the accepting edge. Releases are debounced the
//   same way but never produce `t`.
//
// Parameters:
//   SYNC_STAGES  synchronizer depth on btn (2..4)
//   DB_CYCLES    consecutive identical samples needed to accept a change
//                (2..65535)
//   CNT_W        width of press_cnt
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-high reset, release sampled on clk
//   btn        in   raw button level, asynchronous, may bounce
//   en         in   pulse enable, sampled only at the press-accepting edge
//   t          out  registered one-cycle toggle request
//   db_level   out  registered debounced button level
//   press_cnt  out  number of emitted t pulses, wraps modulo 2^CNT_W
// ---------------------------------------------------------------------------
module t_toggle_req #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DB_CYCLES   = 16,
  parameter int unsigned CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn,
  input  logic             en,
  output logic             t,
  output logic             db_level,
  output logic [CNT_W-1:0] press_cnt
);

  // Debounce counter must hold values up to DB_CYCLES.
  localparam int unsigned DB_W = $clog2(DB_CYCLES + 1);

  // Count value at which the next matching sample accepts the new level.
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,   // stable released, db_level = 0
    ST_ARM_HI = 2'd1,   // counting a candidate press
    ST_HIGH   = 2'd2,   // stable pressed, db_level = 1
    ST_ARM_LO = 2'd3    // counting a candidate release
  } state_e;

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sync_q;
  state_e                 state_q, state_d;
  logic [DB_W-1:0]        cnt_q,   cnt_d;
  logic                   t_q,     t_d;
  logic                   db_q,    db_d;
  logic [CNT_W-1:0]       press_q, press_d;

  // Synchronized button level (last synchronizer stage).
  logic btn_s_c;
  assign btn_s_c = sync_q[SYNC_STAGES-1];

  // Synchronizer chain: btn enters at bit 0 and shifts toward the MSB.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], btn};
    end
  end

  // State, debounce counter and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      t_q     <= 1'b0;
      db_q    <= 1'b0;
      press_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      t_q     <= t_d;
      db_q    <= db_d;
      press_q <= press_d;
    end
  end

  // Next-state, counter and output logic; t defaults low so it is a pulse.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    t_d     = 1'b0;
    db_d    = db_q;
    press_d = press_q;

    unique case (state_q)
      ST_IDLE: begin
        if (btn_s_c) begin
          // This sample is the first of the DB_CYCLES needed.
          state_d = ST_ARM_HI;
          cnt_d   = DB_W'(1);
        end else begin
          cnt_d   = '0;
        end
      end

      ST_ARM_HI: begin
        if (!btn_s_c) begin
          // Bounce: fall back with no visible effect.
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == DB_LAST) begin
          // Press accepted; en decides whether it is reported or consumed.
          state_d = ST_HIGH;
          cnt_d   = '0;
          db_d    = 1'b1;
          if (en) begin
            t_d     = 1'b1;
            press_d = press_q + CNT_W'(1);
          end
        end else begin
          cnt_d   = cnt_q + DB_W'(1);
        end
      end

      ST_HIGH: begin
        if (!btn_s_c) begin
          state_d = ST_ARM_LO;
          cnt_d   = DB_W'(1);
        end else begin
          cnt_d   = '0;
        end
      end

      ST_ARM_LO: begin
        if (btn_s_c) begin
          state_d = ST_HIGH;
          cnt_d   = '0;
        end else if (cnt_q == DB_LAST) begin
          // Release accepted; never produces a toggle request.
          state_d = ST_IDLE;
          cnt_d   = '0;
          db_d    = 1'b0;
        end else begin
          cnt_d   = cnt_q + DB_W'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        db_d    = 1'b0;
      end
    endcase
  end

  assign t         = t_q;
  assign db_level  = db_q;
  assign press_cnt = press_q;

endmodule

// File: tb/tb_t_toggle_req.sv
// ---------------------------------------------------------------------------
// tb_t_toggle_req
//
// Purpose:
//   Scoreboard bench for t_toggle_req (SYNC_STAGES=2, DB_CYCLES=4, CNT_W=4).
//   Stimulus tasks push the expected output event (cycle, t, db_level,
//   press_cnt) whenever they start a press or release; a forked monitor pops
//   and compares whenever the DUT shows a t pulse or a db_level change.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_t_toggle_req;

  localparam int unsigned SYNC_STAGES = 2;
  localparam int unsigned DB_CYCLES   = 4;
  localparam int unsigned CNT_W       = 4;

  // Edges from first capture of btn to the edge that sets t / db_level:
  // 2 synchronizer stages + 4 debounce samples - 1 = 5.
  localparam int LAT = 5;

  typedef struct {
    int              cyc;
    logic            tv;
    logic            dbv;
    logic [CNT_W-1:0] cnt;
  } ev_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             btn = 1'b0;
  logic             en  = 1'b1;
  logic             t;
  logic             db_level;
  logic [CNT_W-1:0] press_cnt;

  int               cyc = 0;
  int               n_cmp = 0;
  int               n_bad = 0;
  logic [CNT_W-1:0] exp_cnt = '0;
  ev_t              exp_q[$];

  t_toggle_req #(
    .SYNC_STAGES (SYNC_STAGES),
    .DB_CYCLES   (DB_CYCLES),
    .CNT_W       (CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .btn       (btn),
    .en        (en),
    .t         (t),
    .db_level  (db_level),
    .press_cnt (press_cnt)
  );

  always #5 clk = ~clk;

  // Posedge count; at a negedge it equals the index of the last active edge.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int expv);
    n_cmp++;
    if (act != expv) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cyc=%0d)", name, act, expv, cyc);
    end
  endtask

  // Queue one expected output event; a t pulse advances the count model.
  task automatic expect_ev(input int at, input logic tv, input logic dbv);
    ev_t ev;
    if (tv) exp_cnt = exp_cnt + 4'd1;
    ev.cyc = at;
    ev.tv  = tv;
    ev.dbv = dbv;
    ev.cnt = exp_cnt;
    exp_q.push_back(ev);
  endtask

  // Clean press: btn first captured at the next posedge E0.
  task automatic press(input logic en_v, input int hold);
    @(negedge clk);
    en  = en_v;
    btn = 1'b1;
    expect_ev(cyc + 1 + LAT, en_v, 1'b1);
    repeat (hold) @(negedge clk);
  endtask

  // Clean release: db_level falls LAT edges after capture, never t.
  task automatic let_go(input int hold);
    @(negedge clk);
    btn = 1'b0;
    expect_ev(cyc + 1 + LAT, 1'b0, 1'b0);
    repeat (hold) @(negedge clk);
  endtask

  // Monitor: any t pulse or db_level change is an output event.
  task automatic monitor();
    ev_t  ev;
    logic prev_db;
    prev_db = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst && (t === 1'b1 || db_level !== prev_db)) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_event: cyc=%0d t=%b db_level=%b press_cnt=%0d, expected no event",
                   cyc, t, db_level, press_cnt);
        end else begin
          ev = exp_q.pop_front();
          if (cyc != ev.cyc || t !== ev.tv || db_level !== ev.dbv || press_cnt !== ev.cnt) begin
            n_bad++;
            $display("FAIL event: got cyc=%0d t=%b db_level=%b press_cnt=%0d, expected cyc=%0d t=%b db_level=%b press_cnt=%0d",
                     cyc, t, db_level, press_cnt, ev.cyc, ev.tv, ev.dbv, ev.cnt);
          end
        end
      end
      prev_db = db_level;
    end
  endtask

  initial begin
    fork
      monitor();
    join_none

    // Reset held while btn toggles: outputs stay at reset values.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      btn = ~btn;
      chk("rst_t", int'(t), 0);
      chk("rst_db_level", int'(db_level), 0);
      chk("rst_press_cnt", int'(press_cnt), 0);
    end

    // Release reset with btn low: nothing happens.
    @(negedge clk);
    btn = 1'b0;
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("idle_t", int'(t), 0);
      chk("idle_db_level", int'(db_level), 0);
    end

    // Bounce: 3 high / 2 low, five times, then low.
    for (int i = 0; i < 5; i++) begin
      btn = 1'b1;
      repeat (3) @(negedge clk);
      btn = 1'b0;
      repeat (2) @(negedge clk);
    end
    repeat (20) @(negedge clk);
    chk("bounce_db_level", int'(db_level), 0);
    chk("bounce_press_cnt", int'(press_cnt), 0);

    // Clean press and release.
    press(1'b1, 20);
    chk("press_db_level", int'(db_level), 1);
    chk("press_press_cnt", int'(press_cnt), 1);
    let_go(20);
    chk("release_db_level", int'(db_level), 0);
    chk("release_press_cnt", int'(press_cnt), 1);

    // Enable gating: press with en=0, raise en while still held.
    press(1'b0, 20);
    chk("gated_db_level", int'(db_level), 1);
    chk("gated_press_cnt", int'(press_cnt), 1);
    @(negedge clk);
    en = 1'b1;
    repeat (10) @(negedge clk);
    chk("late_en_press_cnt", int'(press_cnt), 1);
    let_go(20);
    press(1'b1, 20);
    chk("reenabled_press_cnt", int'(press_cnt), 2);
    let_go(20);

    // Clear the counter, then wrap it: 17 presses pass 15 -> 0 -> 1.
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("clear_press_cnt", int'(press_cnt), 0);
    rst = 1'b0;
    exp_cnt = '0;
    for (int i = 0; i < 17; i++) begin
      press(1'b1, 10);
      if (i == 14) chk("wrap_at_15", int'(press_cnt), 15);
      if (i == 15) chk("wrap_to_0", int'(press_cnt), 0);
      let_go(10);
    end
    chk("wrap_then_1", int'(press_cnt), 1);

    // Async reset pulse while ARM_HI; btn stays high for a fresh press.
    @(negedge clk);
    btn = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    #0.5;
    chk("async_rst_t", int'(t), 0);
    chk("async_rst_db_level", int'(db_level), 0);
    chk("async_rst_press_cnt", int'(press_cnt), 0);
    #0.5;
    rst = 1'b0;
    exp_cnt = '0;
    expect_ev(cyc + 1 + LAT, 1'b1, 1'b1);
    repeat (20) @(negedge clk);
    chk("post_rst_press_cnt", int'(press_cnt), 1);
    let_go(20);

    // Every queued event must have been seen.
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL pending_events: got %0d left, expected 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
